l2_request_arbiter: RTL and testbench
=====================================

Name: l2_request_arbiter

Overview:
- Shares the single blocking read-only L2 cache port between NUM_REQ L1-side requesters (requester 0 = L1 I-cache, requester 1 = L1 D-cache).
- Grants one request at a time, round-robin, and forwards it to the L2 request channel.
- Waits for the L2 line response and routes it back to the granted requester only.
- Keeps saturating per-requester grant counters for performance debug.

Parameters:
- NUM_REQ, 2, number of L1-side requesters (2..8).
- COUNT_WIDTH, 16, width of each saturating grant counter.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous reset, active-low (rst_in == 0 resets on the rising clk_in edge).
- req_valid_in  input  NUM_REQ  per-requester request valid.
- req_ready_out  output  NUM_REQ  per-requester request ready.
- req_address_in  input  NUM_REQ x Word  per-requester request address (packed array).
- resp_valid_out  output  NUM_REQ  per-requester response valid.
- resp_ready_in  input  NUM_REQ  per-requester response ready.
- resp_data_out  output  Line  response line, shared by all requesters.
- l2_request_ready_in  input  1  L2 accepts request.
- l2_request_valid_out  output  1  request to L2.
- l2_request_address_out  output  Word  request address to L2.
- l2_response_ready_out  output  1  arbiter accepts L2 response.
- l2_response_valid_in  input  1  L2 response valid.
- l2_response_data_in  input  Line  L2 response line.
- owner_out  output  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy_out  output  1  high in any state other than IDLE.
- grant_count_out  output  NUM_REQ x COUNT_WIDTH  saturating grant counters.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, owner=0, latched address=0, latched line=0, all counters=0, all valid/ready outputs=0.
- Handshakes: a transfer occurs on the cycle valid&&ready is high at the rising edge.
  - Once raised, valid holds, with stable data, until the transfer.
  - The arbiter's ready outputs may depend combinationally on valid inputs.
- States: IDLE, ISSUE, WAIT_RESP, DELIVER.
- IDLE:
  - winner = first requester with req_valid_in set, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready_out is one-hot on the winner; all zero if no request is valid.
  - On transfer: latch req_address_in[winner], set owner=winner, increment grant_count[winner] (saturating at all-ones), go to ISSUE.
  - Zero latency from valid to grant.
- ISSUE:
  - l2_request_valid_out=1; l2_request_address_out = latched address, stable.
  - On l2_request_ready_in, go to WAIT_RESP.
- WAIT_RESP:
  - l2_response_ready_out=1.
  - On l2_response_valid_in, latch l2_response_data_in and go to DELIVER.
  - No timeout: the arbiter waits indefinitely.
- DELIVER:
  - resp_valid_out[owner]=1, all other bits 0; resp_data_out = latched line.
  - On resp_ready_in[owner]: rr_ptr = (owner+1) mod NUM_REQ, go to IDLE.
  - resp_ready_in bits of non-owners are ignored.
- Minimum round trip: 4 cycles (grant, issue, response, deliver), plus L2 and requester stalls. A new grant is possible on the cycle after DELIVER completes.
- Only one transaction is outstanding at a time. New requests wait with req_ready_out=0 while busy_out=1.
- Fairness: two requesters holding valid continuously alternate grants 0,1,0,1...
  - A lone requester is re-granted back-to-back regardless of rr_ptr.
- rr_ptr changes only when DELIVER completes, never in IDLE.
- Reset mid-operation: return to reset values in one cycle; the in-flight transaction is dropped with no response. The L2 shares the reset and is reset with it.
- resp_data_out and l2_request_address_out hold their last latched values outside DELIVER and ISSUE respectively.
- Illegal or unused state encodings go to IDLE.

Decomposition:
- Word and Line come from help; ArbiterState (the state enum) belongs in cache_help.
- One sub-module: rr_priority_picker, a parameterized combinational round-robin one-hot picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any-valid flag.
  - Reused later for the L2-to-memory arbiter.

Test Plan:
- Single requester: req0 valid with address 0x0000_1040; L2 ready immediately; response line 0xA5.. one cycle after the request transfer.
  - Expect l2_request_address_out=0x0000_1040, resp_valid_out=2'b01 with the line, and grant_count[0]=1.
- Simultaneous requests: req0 and req1 both valid at rr_ptr=0, addresses 0x100 and 0x200.
  - Expect the L2 to see 0x100 then 0x200; resp_valid_out is 01 then 10; owner_out is 0 then 1.
- Backpressure: hold l2_request_ready_in=0 for 5 cycles, then hold resp_ready_in[owner]=0 for 3 cycles.
  - Expect address, valid, and data stable throughout; req_ready_out=0 while busy_out=1.
- Fairness: both requesters always valid for 10 transactions.
  - Expect strict alternation 0,1,0,1... and grant counts 5/5.
- Reset mid-flight: drive rst_in=0 for one cycle during WAIT_RESP.
  - Expect the next cycle state=IDLE, all valids 0, counters 0, and rr_ptr=0; a following req1 is granted normally.
- Counter saturation: COUNT_WIDTH=2, 5 grants to requester 1.
  - Expect grant_count[1]=3; the other counter is unaffected.

Source files
------------

// File: rtl/cache_help_pkg.sv
// Shared cache-side FSM definitions for the L2 request arbiter.
package cache_help;

    typedef logic [1:0] ArbiterState;

    localparam ArbiterState IDLE      = 2'd0;
    localparam ArbiterState ISSUE     = 2'd1;
    localparam ArbiterState WAIT_RESP = 2'd2;
    localparam ArbiterState DELIVER   = 2'd3;

endpackage

// File: rtl/help_pkg.sv
// Common datapath types: request address word and cache line.
package help;

    localparam int WORD_WIDTH = 32;
    localparam int LINE_WIDTH = 64;

    typedef logic [WORD_WIDTH-1:0] Word;
    typedef logic [LINE_WIDTH-1:0] Line;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr_in, wrapping.
module rr_priority_picker #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [IDX_W-1:0]   ptr_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic [IDX_W-1:0]   index_out,
    output logic               any_out
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_out = '0;
        index_out = '0;
        any_out   = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_in) + i) % NUM_REQ);
            if (!any_out && req_in[cand]) begin
                any_out   = 1'b1;
                index_out = cand;
            end
        end
        grant_out[index_out] = any_out;
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter sharing one blocking L2 read port between L1 requesters,
// one transaction in flight, with saturating per-requester grant counters.
module l2_request_arbiter
    import help::*;
    import cache_help::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int COUNT_WIDTH = 16,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic [NUM_REQ-1:0]                    req_valid_in,
    output logic [NUM_REQ-1:0]                    req_ready_out,
    input  logic [NUM_REQ-1:0][WORD_WIDTH-1:0]    req_address_in,
    output logic [NUM_REQ-1:0]                    resp_valid_out,
    input  logic [NUM_REQ-1:0]                    resp_ready_in,
    output logic [LINE_WIDTH-1:0]                 resp_data_out,
    input  logic                                  l2_request_ready_in,
    output logic                                  l2_request_valid_out,
    output logic [WORD_WIDTH-1:0]                 l2_request_address_out,
    output logic                                  l2_response_ready_out,
    input  logic                                  l2_response_valid_in,
    input  logic [LINE_WIDTH-1:0]                 l2_response_data_in,
    output logic [IDX_W-1:0]                      owner_out,
    output logic                                  busy_out,
    output logic [NUM_REQ-1:0][COUNT_WIDTH-1:0]   grant_count_out
);

    ArbiterState                           state_q, state_d;
    logic [IDX_W-1:0]                      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                      owner_q, owner_d;
    Word                                   addr_q, addr_d;
    Line                                   line_q, line_d;
    logic [NUM_REQ-1:0][COUNT_WIDTH-1:0]   count_q, count_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_index;
    logic               pick_any;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_in    (req_valid_in),
        .ptr_in    (rr_ptr_q),
        .grant_out (pick_grant),
        .index_out (pick_index),
        .any_out   (pick_any)
    );

    always_comb begin
        state_d               = state_q;
        rr_ptr_d              = rr_ptr_q;
        owner_d               = owner_q;
        addr_d                = addr_q;
        line_d                = line_q;
        count_d               = count_q;
        req_ready_out         = '0;
        l2_request_valid_out  = 1'b0;
        l2_response_ready_out = 1'b0;
        resp_valid_out        = '0;

        case (state_q)
            IDLE: begin
                // Ready is offered only to the picked winner, so any valid is a transfer.
                req_ready_out = pick_grant;
                if (pick_any) begin
                    addr_d  = req_address_in[pick_index];
                    owner_d = pick_index;
                    if (count_q[pick_index] != '1) begin
                        count_d[pick_index] = count_q[pick_index] + COUNT_WIDTH'(1);
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                l2_request_valid_out = 1'b1;
                if (l2_request_ready_in) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                l2_response_ready_out = 1'b1;
                if (l2_response_valid_in) begin
                    line_d  = l2_response_data_in;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                resp_valid_out[owner_q] = 1'b1;
                if (resp_ready_in[owner_q]) begin
                    rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            addr_q   <= '0;
            line_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            line_q   <= line_d;
            count_q  <= count_d;
        end
    end

    assign l2_request_address_out = addr_q;
    assign resp_data_out          = line_q;
    assign owner_out              = owner_q;
    assign busy_out               = (state_q != IDLE);
    assign grant_count_out        = count_q;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_l2_request_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0][31:0]  req_addr;
    logic [1:0]        resp_ready;
    logic              l2_rq_ready;
    logic              l2_rs_valid;
    logic [63:0]       l2_rs_data;

    logic [1:0]        req_ready;
    logic [1:0]        resp_valid;
    logic [63:0]       resp_data;
    logic              l2_rq_valid;
    logic [31:0]       l2_rq_addr;
    logic              l2_rs_ready;
    logic              owner;
    logic              busy;
    logic [1:0][15:0]  gcount;

    logic [1:0]        req_ready2;
    logic [1:0]        resp_valid2;
    logic [63:0]       resp_data2;
    logic              l2_rq_valid2;
    logic [31:0]       l2_rq_addr2;
    logic              l2_rs_ready2;
    logic              owner2;
    logic              busy2;
    logic [1:0][1:0]   gcount2;

    l2_request_arbiter #(
        .NUM_REQ     (2),
        .COUNT_WIDTH (16)
    ) dut (
        .clk_in                 (clk),
        .rst_in                 (rst_n),
        .req_valid_in           (req_valid),
        .req_ready_out          (req_ready),
        .req_address_in         (req_addr),
        .resp_valid_out         (resp_valid),
        .resp_ready_in          (resp_ready),
        .resp_data_out          (resp_data),
        .l2_request_ready_in    (l2_rq_ready),
        .l2_request_valid_out   (l2_rq_valid),
        .l2_request_address_out (l2_rq_addr),
        .l2_response_ready_out  (l2_rs_ready),
        .l2_response_valid_in   (l2_rs_valid),
        .l2_response_data_in    (l2_rs_data),
        .owner_out              (owner),
        .busy_out               (busy),
        .grant_count_out        (gcount)
    );

    // Narrow-counter twin sharing all stimulus, for saturation checks.
    l2_request_arbiter #(
        .NUM_REQ     (2),
        .COUNT_WIDTH (2)
    ) dut_sat (
        .clk_in                 (clk),
        .rst_in                 (rst_n),
        .req_valid_in           (req_valid),
        .req_ready_out          (req_ready2),
        .req_address_in         (req_addr),
        .resp_valid_out         (resp_valid2),
        .resp_ready_in          (resp_ready),
        .resp_data_out          (resp_data2),
        .l2_request_ready_in    (l2_rq_ready),
        .l2_request_valid_out   (l2_rq_valid2),
        .l2_request_address_out (l2_rq_addr2),
        .l2_response_ready_out  (l2_rs_ready2),
        .l2_response_valid_in   (l2_rs_valid),
        .l2_response_data_in    (l2_rs_data),
        .owner_out              (owner2),
        .busy_out               (busy2),
        .grant_count_out        (gcount2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  rv;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        l2rr;
        logic        l2rv;
        logic [63:0] l2d;
        logic [1:0]  rr;
        logic [1:0]  e_rdy;
        logic        e_l2v;
        logic [31:0] e_addr;
        logic        e_l2rdy;
        logic [1:0]  e_rv;
        logic [63:0] e_data;
        logic        e_own;
        logic        e_busy;
    } vec_t;

    localparam int NV = 17;
    localparam logic [31:0] A  = 32'h0000_1040;
    localparam logic [63:0] D  = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] L1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] L2 = 64'h2222_2222_2222_2222;
    localparam logic [31:0] B0 = 32'h0000_0100;
    localparam logic [31:0] B1 = 32'h0000_0200;

    vec_t vecs [NV];

    // One full transaction starting in IDLE; vld is held for the whole transaction.
    task automatic run_txn(input logic [1:0] vld, input int exp_own, input logic [31:0] exp_addr,
                           input logic [63:0] line, input string tag);
        logic [1:0] oh;
        oh = (exp_own == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        req_valid = vld; l2_rq_ready = 1'b0; l2_rs_valid = 1'b0; resp_ready = 2'b00;
        #1;
        check({tag, ".grant"}, 64'(req_ready), 64'(oh));
        @(negedge clk);
        l2_rq_ready = 1'b1;
        #1;
        check({tag, ".l2_addr"}, 64'(l2_rq_addr), 64'(exp_addr));
        check({tag, ".owner"}, 64'(owner), 64'(exp_own));
        check({tag, ".no_ready_busy"}, 64'(req_ready), 64'h0);
        @(negedge clk);
        l2_rq_ready = 1'b0; l2_rs_valid = 1'b1; l2_rs_data = line;
        #1;
        check({tag, ".l2_rs_ready"}, 64'(l2_rs_ready), 64'h1);
        @(negedge clk);
        l2_rs_valid = 1'b0; resp_ready = 2'b11;
        #1;
        check({tag, ".resp_valid"}, 64'(resp_valid), 64'(oh));
        check({tag, ".resp_data"}, resp_data, line);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_addr = '0; resp_ready = '0;
        l2_rq_ready = 1'b0; l2_rs_valid = 1'b0; l2_rs_data = '0;

        // rst rv a0 a1 l2rr l2rv l2d rr | rdy l2v addr l2rdy rv data own busy
        vecs[0]  = '{1'b0, 2'b00, A, 32'h0, 1'b0, 1'b0, 64'h0, 2'b00,
                     2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b01, A, 32'h0, 1'b0, 1'b0, 64'h0, 2'b00,
                     2'b01, 1'b0, 32'h0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, A, 32'h0, 1'b1, 1'b0, 64'h0, 2'b00,
                     2'b00, 1'b1, A, 1'b0, 2'b00, 64'h0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 2'b00, A, 32'h0, 1'b0, 1'b1, D, 2'b00,
                     2'b00, 1'b0, A, 1'b1, 2'b00, 64'h0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 2'b00, A, 32'h0, 1'b0, 1'b0, 64'h0, 2'b01,
                     2'b00, 1'b0, A, 1'b0, 2'b01, D, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 2'b00, A, 32'h0, 1'b0, 1'b0, 64'h0, 2'b00,
                     2'b00, 1'b0, A, 1'b0, 2'b00, D, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 2'b00, A, 32'h0, 1'b0, 1'b0, 64'h0, 2'b00,
                     2'b00, 1'b0, A, 1'b0, 2'b00, D, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 2'b11, B0, B1, 1'b0, 1'b0, 64'h0, 2'b00,
                     2'b01, 1'b0, 32'h0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 2'b11, B0, B1, 1'b1, 1'b0, 64'h0, 2'b00,
                     2'b00, 1'b1, B0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 2'b10, B0, B1, 1'b0, 1'b1, L1, 2'b00,
                     2'b00, 1'b0, B0, 1'b1, 2'b00, 64'h0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 2'b10, B0, B1, 1'b0, 1'b0, 64'h0, 2'b11,
                     2'b00, 1'b0, B0, 1'b0, 2'b01, L1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 2'b10, B0, B1, 1'b0, 1'b0, 64'h0, 2'b00,
                     2'b10, 1'b0, B0, 1'b0, 2'b00, L1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 2'b00, B0, B1, 1'b1, 1'b0, 64'h0, 2'b00,
                     2'b00, 1'b1, B1, 1'b0, 2'b00, L1, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 2'b00, B0, B1, 1'b0, 1'b1, L2, 2'b00,
                     2'b00, 1'b0, B1, 1'b1, 2'b00, L1, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 2'b00, B0, B1, 1'b0, 1'b0, 64'h0, 2'b01,
                     2'b00, 1'b0, B1, 1'b0, 2'b10, L2, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 2'b00, B0, B1, 1'b0, 1'b0, 64'h0, 2'b10,
                     2'b00, 1'b0, B1, 1'b0, 2'b10, L2, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 2'b00, B0, B1, 1'b0, 1'b0, 64'h0, 2'b00,
                     2'b00, 1'b0, B1, 1'b0, 2'b00, L2, 1'b1, 1'b0};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n       = vecs[i].rst;
            req_valid   = vecs[i].rv;
            req_addr[0] = vecs[i].a0;
            req_addr[1] = vecs[i].a1;
            l2_rq_ready = vecs[i].l2rr;
            l2_rs_valid = vecs[i].l2rv;
            l2_rs_data  = vecs[i].l2d;
            resp_ready  = vecs[i].rr;
            #1;
            check($sformatf("row%0d.req_ready", i), 64'(req_ready), 64'(vecs[i].e_rdy));
            check($sformatf("row%0d.l2_valid", i), 64'(l2_rq_valid), 64'(vecs[i].e_l2v));
            check($sformatf("row%0d.l2_addr", i), 64'(l2_rq_addr), 64'(vecs[i].e_addr));
            check($sformatf("row%0d.l2_rs_ready", i), 64'(l2_rs_ready), 64'(vecs[i].e_l2rdy));
            check($sformatf("row%0d.resp_valid", i), 64'(resp_valid), 64'(vecs[i].e_rv));
            check($sformatf("row%0d.resp_data", i), resp_data, vecs[i].e_data);
            check($sformatf("row%0d.owner", i), 64'(owner), 64'(vecs[i].e_own));
            check($sformatf("row%0d.busy", i), 64'(busy), 64'(vecs[i].e_busy));
        end
        check("table.count0", 64'(gcount[0]), 64'd1);
        check("table.count1", 64'(gcount[1]), 64'd1);

        // Backpressure on both L2 request and requester response.
        @(negedge clk);
        req_valid = 2'b01; req_addr[0] = 32'h0000_0300; resp_ready = 2'b00;
        #1;
        check("bp.grant", 64'(req_ready), 64'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 2'b11; l2_rq_ready = 1'b0;
            #1;
            check($sformatf("bp.stall%0d.l2_valid", i), 64'(l2_rq_valid), 64'h1);
            check($sformatf("bp.stall%0d.l2_addr", i), 64'(l2_rq_addr), 64'h300);
            check($sformatf("bp.stall%0d.req_ready", i), 64'(req_ready), 64'h0);
            check($sformatf("bp.stall%0d.busy", i), 64'(busy), 64'h1);
        end
        @(negedge clk);
        l2_rq_ready = 1'b1;
        #1;
        check("bp.issue", 64'(l2_rq_valid), 64'h1);
        @(negedge clk);
        l2_rq_ready = 1'b0; l2_rs_valid = 1'b1; l2_rs_data = 64'h3333_3333_3333_3333;
        #1;
        check("bp.l2_rs_ready", 64'(l2_rs_ready), 64'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            l2_rs_valid = 1'b0; l2_rs_data = '0; resp_ready = 2'b00;
            #1;
            check($sformatf("bp.dstall%0d.resp_valid", i), 64'(resp_valid), 64'h1);
            check($sformatf("bp.dstall%0d.resp_data", i), resp_data, 64'h3333_3333_3333_3333);
            check($sformatf("bp.dstall%0d.req_ready", i), 64'(req_ready), 64'h0);
        end
        @(negedge clk);
        resp_ready = 2'b01;
        #1;
        check("bp.deliver", 64'(resp_valid), 64'h1);
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        check("bp.next_grant", 64'(req_ready), 64'h2);
        req_valid = 2'b00; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness: both requesters continuously valid.
        req_addr[0] = 32'h0000_0400; req_addr[1] = 32'h0000_0500;
        for (int i = 0; i < 10; i++) begin
            run_txn(2'b11, i % 2, (i % 2 == 0) ? 32'h400 : 32'h500, 64'(i + 16),
                    $sformatf("fair%0d", i));
        end
        @(negedge clk);
        req_valid = 2'b00; resp_ready = 2'b00;
        #1;
        check("fair.count0", 64'(gcount[0]), 64'd5);
        check("fair.count1", 64'(gcount[1]), 64'd5);
        check("fair.sat_count0", 64'(gcount2[0]), 64'd3);
        check("fair.sat_count1", 64'(gcount2[1]), 64'd3);

        // Reset mid-flight after moving rr_ptr to 1; lone req0 is still re-granted.
        run_txn(2'b01, 0, 32'h400, 64'h77, "pre_rst");
        @(negedge clk);
        req_valid = 2'b01; resp_ready = 2'b00;
        #1;
        check("rst.lone_regrant", 64'(req_ready), 64'h1);
        @(negedge clk);
        req_valid = 2'b00; l2_rq_ready = 1'b1;
        @(negedge clk);
        l2_rq_ready = 1'b0;
        #1;
        check("rst.in_wait", 64'(l2_rs_ready), 64'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.busy", 64'(busy), 64'h0);
        check("rst.l2_valid", 64'(l2_rq_valid), 64'h0);
        check("rst.l2_rs_ready", 64'(l2_rs_ready), 64'h0);
        check("rst.resp_valid", 64'(resp_valid), 64'h0);
        check("rst.owner", 64'(owner), 64'h0);
        check("rst.l2_addr", 64'(l2_rq_addr), 64'h0);
        check("rst.count0", 64'(gcount[0]), 64'h0);
        check("rst.count1", 64'(gcount[1]), 64'h0);
        req_valid = 2'b11;
        #1;
        check("rst.rr_ptr0", 64'(req_ready), 64'h1);
        req_valid = 2'b00;

        // Requester 1 granted normally, then four more grants to saturate the 2-bit twin.
        for (int i = 0; i < 5; i++) begin
            run_txn(2'b10, 1, 32'h500, 64'(i + 64), $sformatf("sat%0d", i));
        end
        @(negedge clk);
        req_valid = 2'b00; resp_ready = 2'b00;
        #1;
        check("sat.count1", 64'(gcount[1]), 64'd5);
        check("sat.count0", 64'(gcount[0]), 64'd0);
        check("sat.sat_count1", 64'(gcount2[1]), 64'd3);
        check("sat.sat_count0", 64'(gcount2[0]), 64'd0);
        check("sat.idle", 64'(busy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
